// File: rtl/bk_sram_arbiter.sv
// bk_sram_arbiter: shares one 16-bit asynchronous SRAM between video refill, CPU and JTAG debug,
// running a fixed-length strobe cycle per access and a one-cycle acknowledge to the owner.
`default_nettype none

module bk_sram_arbiter #(
    parameter int         WAIT_STATES = 3,
    parameter logic [4:0] VID_BASE    = 5'b00001
) (
    input  logic        clk_cpu,
    input  logic        reset_in,

    input  logic        cpu_rd,
    input  logic        cpu_wt,
    input  logic [17:0] cpu_adr,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_reply,
    output logic [15:0] cpu_rdata,

    input  logic        dbg_en,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [17:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,

    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_rdata,

    output logic [17:0] ram_addr,
    output logic [15:0] ram_dataw,
    input  logic [15:0] ram_datar,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic        ram_lb_n,
    output logic        ram_ub_n,
    output logic        ram_busy,
    output logic [1:0]  grant
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;
    localparam logic [1:0] OWN_VID  = 2'd3;
    localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  vid_streak;
    logic        wr_q;

    logic        cpu_any;
    logic        dbg_valid;
    logic [1:0]  pick;
    logic [17:0] nxt_addr;
    logic        nxt_wr;
    logic        nxt_lb_n;
    logic        nxt_ub_n;
    logic [15:0] nxt_wdata;

    assign cpu_any   = cpu_rd | cpu_wt;
    assign dbg_valid = dbg_en & dbg_req;

    // Two video grants in a row hand the next slot to a waiting CPU.
    always_comb begin
        pick = OWN_NONE;
        if (cpu_any && vid_streak[1])
            pick = OWN_CPU;
        else if (vid_req)
            pick = OWN_VID;
        else if (cpu_any)
            pick = OWN_CPU;
        else if (dbg_valid)
            pick = OWN_DBG;
    end

    always_comb begin
        nxt_addr  = 18'd0;
        nxt_wr    = 1'b0;
        nxt_lb_n  = 1'b0;
        nxt_ub_n  = 1'b0;
        nxt_wdata = 16'hFFFF;
        case (pick)
            OWN_CPU: begin
                nxt_addr  = {1'b0, cpu_adr[17:1]};
                nxt_wr    = ~cpu_rd & cpu_wt;
                nxt_lb_n  = cpu_byte & cpu_adr[0];
                nxt_ub_n  = cpu_byte & ~cpu_adr[0];
                nxt_wdata = cpu_wdata;
            end
            OWN_DBG: begin
                nxt_addr  = dbg_addr;
                nxt_wr    = dbg_we;
                nxt_wdata = dbg_wdata;
            end
            OWN_VID: begin
                nxt_addr  = {VID_BASE, vid_addr};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_cpu or posedge reset_in) begin
        if (reset_in) begin
            state      <= ST_IDLE;
            cnt        <= 3'd0;
            vid_streak <= 2'd0;
            wr_q       <= 1'b0;
            grant      <= OWN_NONE;
            ram_busy   <= 1'b0;
            ram_addr   <= 18'd0;
            ram_dataw  <= 16'hFFFF;
            ram_oe_n   <= 1'b1;
            ram_we_n   <= 1'b1;
            ram_lb_n   <= 1'b1;
            ram_ub_n   <= 1'b1;
            cpu_reply  <= 1'b0;
            dbg_ack    <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdata  <= 16'h0000;
            dbg_rdata  <= 16'h0000;
            vid_rdata  <= 16'h0000;
        end else begin
            cpu_reply <= 1'b0;
            dbg_ack   <= 1'b0;
            vid_ack   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick != OWN_NONE) begin
                        state     <= ST_ACCESS;
                        grant     <= pick;
                        ram_busy  <= 1'b1;
                        cnt       <= CNT_INIT;
                        wr_q      <= nxt_wr;
                        ram_addr  <= nxt_addr;
                        ram_oe_n  <= nxt_wr;
                        ram_we_n  <= ~nxt_wr;
                        ram_lb_n  <= nxt_lb_n;
                        ram_ub_n  <= nxt_ub_n;
                        ram_dataw <= nxt_wr ? nxt_wdata : 16'hFFFF;
                        if (pick == OWN_VID) begin
                            if (vid_streak != 2'd3)
                                vid_streak <= vid_streak + 2'd1;
                        end else begin
                            vid_streak <= 2'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 3'd0) begin
                        state     <= ST_RECOVER;
                        ram_oe_n  <= 1'b1;
                        ram_we_n  <= 1'b1;
                        ram_lb_n  <= 1'b1;
                        ram_ub_n  <= 1'b1;
                        ram_dataw <= 16'hFFFF;
                        case (grant)
                            OWN_CPU: begin
                                cpu_reply <= 1'b1;
                                if (!wr_q) cpu_rdata <= ram_datar;
                            end
                            OWN_DBG: begin
                                dbg_ack <= 1'b1;
                                if (!wr_q) dbg_rdata <= ram_datar;
                            end
                            OWN_VID: begin
                                vid_ack <= 1'b1;
                                if (!wr_q) vid_rdata <= ram_datar;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RECOVER: begin
                    state    <= ST_IDLE;
                    grant    <= OWN_NONE;
                    ram_busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    grant    <= OWN_NONE;
                    ram_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bk_sram_arbiter.sv
// Directed self-checking bench for bk_sram_arbiter (default parameters).
`default_nettype none

module tb_bk_sram_arbiter;

    logic        clk_cpu = 1'b0;
    logic        reset_in = 1'b0;
    logic        cpu_rd = 1'b0, cpu_wt = 1'b0, cpu_byte = 1'b0;
    logic [17:0] cpu_adr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_reply;
    logic [15:0] cpu_rdata;
    logic        dbg_en = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [17:0] dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;
    logic        dbg_ack;
    logic [15:0] dbg_rdata;
    logic        vid_req = 1'b0;
    logic [12:0] vid_addr = '0;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic [17:0] ram_addr;
    logic [15:0] ram_dataw;
    logic [15:0] ram_datar = '0;
    logic        ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n, ram_busy;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_bad = 0;
    int both_low = 0;

    bk_sram_arbiter dut (
        .clk_cpu(clk_cpu), .reset_in(reset_in),
        .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_adr(cpu_adr), .cpu_byte(cpu_byte),
        .cpu_wdata(cpu_wdata), .cpu_reply(cpu_reply), .cpu_rdata(cpu_rdata),
        .dbg_en(dbg_en), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .ram_addr(ram_addr), .ram_dataw(ram_dataw), .ram_datar(ram_datar),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
        .ram_busy(ram_busy), .grant(grant)
    );

    always #5 clk_cpu = ~clk_cpu;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_cpu);
        #1;
        if (!ram_oe_n && !ram_we_n) both_low++;
    endtask

    function automatic logic ack_of(input logic [1:0] who);
        case (who)
            2'd1:    return cpu_reply;
            2'd2:    return dbg_ack;
            2'd3:    return vid_ack;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drop(input logic [1:0] who);
        case (who)
            2'd1:    begin cpu_rd = 1'b0; cpu_wt = 1'b0; end
            2'd2:    dbg_req = 1'b0;
            2'd3:    vid_req = 1'b0;
            default: ;
        endcase
    endtask

    // Steps until the owner's ack, dropping its request then, and records what the SRAM pins showed.
    task automatic run_until_ack(input logic [1:0] who, input int budget,
                                 output int oe_cyc, output int we_cyc,
                                 output logic [17:0] addr_seen, output logic [1:0] lanes_seen,
                                 output logic [15:0] dw_seen, output int wait_cyc);
        logic got;
        got = 1'b0; oe_cyc = 0; we_cyc = 0; wait_cyc = 0;
        addr_seen = '1; lanes_seen = 2'b11; dw_seen = '0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            wait_cyc = i + 1;
            if (!ram_oe_n || !ram_we_n) begin
                addr_seen  = ram_addr;
                lanes_seen = {ram_ub_n, ram_lb_n};
            end
            if (!ram_oe_n) oe_cyc++;
            if (!ram_we_n) begin we_cyc++; dw_seen = ram_dataw; end
            if (ack_of(who)) begin got = 1'b1; drop(who); end
        end
        if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
    endtask

    int          oe_c, we_c, wt_c, n_g, ack_cnt, bad_cnt;
    logic [17:0] a_seen, vid_addr_seen;
    logic [1:0]  l_seen;
    logic [15:0] d_seen;
    logic [1:0]  g_list [0:3];
    logic        prev_busy, done;

    initial begin
        // ---------------- reset values
        #2 reset_in = 1'b1;
        tick(); tick();
        check_eq("rst_grant_busy", {30'd0, grant} | {31'd0, ram_busy} << 4, 32'd0);
        check_eq("rst_strobes", {ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 4'hF);
        check_eq("rst_dataw_addr", {ram_dataw, 14'd0, ram_addr[1:0]} | {16'd0, 14'd0, 2'd0}, 32'hFFFF0000);
        check_eq("rst_addr", ram_addr, 18'd0);
        check_eq("rst_acks_rdata", {cpu_reply, dbg_ack, vid_ack, cpu_rdata | dbg_rdata | vid_rdata}, 32'd0);
        reset_in = 1'b0;
        tick();

        // ---------------- CPU word read
        ram_datar = 16'h1234; cpu_adr = 18'o40002; cpu_rd = 1'b1;
        run_until_ack(2'd1, 20, oe_c, we_c, a_seen, l_seen, d_seen, wt_c);
        check_eq("cpu_rd_addr", a_seen, 18'h2001);
        check_eq("cpu_rd_oe_cycles", oe_c, 4);
        check_eq("cpu_rd_we_cycles", we_c, 0);
        check_eq("cpu_rd_lanes", l_seen, 2'b00);
        check_eq("cpu_rd_latency", wt_c, 5);
        check_eq("cpu_rd_data", cpu_rdata, 16'h1234);
        tick();
        check_eq("cpu_rd_ack_onecycle", {cpu_reply, ram_busy}, 2'b00);
        check_eq("cpu_rd_data_held", cpu_rdata, 16'h1234);

        // ---------------- CPU byte write, odd address
        cpu_adr = 18'o1001; cpu_wdata = 16'hAB00; cpu_byte = 1'b1; cpu_wt = 1'b1;
        run_until_ack(2'd1, 20, oe_c, we_c, a_seen, l_seen, d_seen, wt_c);
        check_eq("cpu_bw_lanes", l_seen, 2'b01);
        check_eq("cpu_bw_we_cycles", we_c, 4);
        check_eq("cpu_bw_oe_cycles", oe_c, 0);
        check_eq("cpu_bw_dataw", d_seen, 16'hAB00);
        check_eq("cpu_bw_addr", a_seen, 18'h0100);
        check_eq("cpu_bw_rdata_kept", cpu_rdata, 16'h1234);
        tick();
        check_eq("cpu_bw_idle_dataw", ram_dataw, 16'hFFFF);

        // ---------------- CPU byte read, even address
        cpu_adr = 18'o1000; cpu_rd = 1'b1; ram_datar = 16'h00CD;
        run_until_ack(2'd1, 20, oe_c, we_c, a_seen, l_seen, d_seen, wt_c);
        check_eq("cpu_br_lanes", l_seen, 2'b10);
        check_eq("cpu_br_data", cpu_rdata, 16'h00CD);
        cpu_byte = 1'b0;
        tick();

        // ---------------- simultaneous requests: video, CPU, debug
        vid_addr = 13'h0005; cpu_adr = 18'o40002; dbg_addr = 18'h00123; dbg_we = 1'b0;
        dbg_en = 1'b1; vid_req = 1'b1; cpu_rd = 1'b1; dbg_req = 1'b1;
        n_g = 0; prev_busy = 1'b0; done = 1'b0; vid_addr_seen = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            ram_datar = 16'hA000 | {14'd0, grant};
            if (ram_busy && !prev_busy && n_g < 4) begin g_list[n_g] = grant; n_g++; end
            if (ram_busy && grant == 2'd3 && !ram_oe_n) vid_addr_seen = ram_addr;
            prev_busy = ram_busy;
            if (vid_ack) drop(2'd3);
            if (cpu_reply) drop(2'd1);
            if (dbg_ack) begin drop(2'd2); done = 1'b1; end
        end
        check_eq("sim_count", n_g, 3);
        check_eq("sim_order", {g_list[0], g_list[1], g_list[2]}, {2'd3, 2'd1, 2'd2});
        check_eq("sim_vid_addr", vid_addr_seen, 18'h2005);
        check_eq("sim_vid_rdata", vid_rdata, 16'hA003);
        check_eq("sim_cpu_rdata", cpu_rdata, 16'hA001);
        check_eq("sim_dbg_rdata", dbg_rdata, 16'hA002);
        tick();

        // ---------------- anti-starvation
        vid_req = 1'b1; cpu_rd = 1'b1;
        n_g = 0; prev_busy = 1'b0;
        for (int i = 0; i < 60 && n_g < 4; i++) begin
            tick();
            if (ram_busy && !prev_busy) begin g_list[n_g] = grant; n_g++; end
            prev_busy = ram_busy;
            if (cpu_reply) drop(2'd1);
        end
        vid_req = 1'b0;
        check_eq("starve_count", n_g, 4);
        check_eq("starve_order", {g_list[0], g_list[1], g_list[2], g_list[3]},
                 {2'd3, 2'd3, 2'd1, 2'd3});
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!ram_busy) done = 1'b1;
        end
        check_eq("starve_drain", done, 1'b1);

        // ---------------- debug gating then debug write
        dbg_en = 1'b0; dbg_req = 1'b1; ack_cnt = 0; bad_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (dbg_ack) ack_cnt++;
            if (ram_busy) bad_cnt++;
        end
        check_eq("dbg_gated_ack", ack_cnt, 0);
        check_eq("dbg_gated_busy", bad_cnt, 0);
        dbg_en = 1'b1; dbg_we = 1'b1; dbg_addr = 18'h08000; dbg_wdata = 16'h5A5A;
        run_until_ack(2'd2, 20, oe_c, we_c, a_seen, l_seen, d_seen, wt_c);
        check_eq("dbg_wr_addr", a_seen, 18'h08000);
        check_eq("dbg_wr_lanes", l_seen, 2'b00);
        check_eq("dbg_wr_we_cycles", we_c, 4);
        check_eq("dbg_wr_dataw", d_seen, 16'h5A5A);
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dbg_ack) ack_cnt++;
        end
        check_eq("dbg_wr_single_ack", ack_cnt, 0);
        check_eq("dbg_rdata_kept", dbg_rdata, 16'hA002);

        // ---------------- reset during a write access
        cpu_adr = 18'o40002; cpu_wdata = 16'h7777; cpu_wt = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (!ram_we_n) done = 1'b1;
        end
        check_eq("rstmid_started", done, 1'b1);
        tick();
        #1 reset_in = 1'b1;
        #1;
        check_eq("rstmid_we_async", {ram_we_n, ram_oe_n, ram_busy}, 3'b110);
        cpu_wt = 1'b0;
        tick(); tick();
        reset_in = 1'b0;
        bad_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (grant != 2'd0 || ram_busy || cpu_reply || dbg_ack || vid_ack) bad_cnt++;
        end
        check_eq("rstmid_quiet", bad_cnt, 0);
        check_eq("rstmid_rdata_cleared", cpu_rdata, 16'h0000);

        check_eq("oe_we_never_both_low", both_low, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
